ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter in front of the single-port 16x8 SRAM: wr, addr[3:0], wdata[7:0], rdata[7:0].
- Accepts at most one access per cycle using round-robin priority and drives the RAM port from registers.
- Returns read data to the requester that issued the read, tagged in order.
- Sits between the test/driver agents (or DMA-style masters) and the RAM.

Parameters:
- DW, 8, data width (matches RAM wdata/rdata)
- AW, 4, address width (16 locations)
- RD_LAT, 1, RAM read latency in cycles from ram_addr valid to ram_rdata valid (1..4)
- RR_EN, 1, 1 = round-robin priority; 0 = fixed priority, requester 0 wins

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 access request
- wr0  in  1  requester 0 write (1) / read (0)
- addr0  in  AW  requester 0 address
- wdata0  in  DW  requester 0 write data
- gnt0  out  1  requester 0 access accepted this cycle
- rvalid0  out  1  read data valid for requester 0
- req1/wr1/addr1/wdata1/gnt1/rvalid1  same as requester 0, for requester 1
- rdata  out  DW  shared read-return data, qualified by rvalid0/rvalid1
- ram_wr  out  1  RAM write strobe
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data

Behaviour:
- Reset:
  - Asynchronous assertion (rst=0) clears: ram_wr=0, ram_addr=0, ram_wdata=0, rvalid0=rvalid1=0, rdata=0.
  - Clears the priority pointer to requester 0 and flushes the read-tag pipeline.
  - Deassertion is synchronous to clk; the first grant can occur in the first cycle after release.
- Handshake:
  - A transfer occurs in cycle T when reqN=1 and gntN=1.
  - The requester holds wrN/addrN/wdataN stable while reqN=1 and gntN=0.
  - gnt is combinational from req and the pointer. gnt0 and gnt1 are never both 1.
- Arbitration:
  - Only one request: grant it.
  - Both requesting, RR_EN=1: grant the requester the pointer favours. The pointer then moves to the other requester; it updates only on a grant.
  - Both requesting, RR_EN=0: requester 0 always wins.
- Issue:
  - On a grant in cycle T, the granted wr/addr/wdata are registered onto ram_wr/ram_addr/ram_wdata for cycle T+1.
  - With no grant, ram_wr=0 in T+1. ram_addr/ram_wdata hold their previous value (no spurious writes).
- Read return:
  - A granted read pushes a tag (valid, requester id) into a shift pipeline of depth 1+RD_LAT.
  - When the tag emerges, ram_rdata is registered into rdata and the matching rvalidN pulses for one cycle.
  - Total latency from read grant to rvalid = RD_LAT+2 cycles (3 with default).
  - Accesses complete in grant order. Back-to-back reads sustain 1 per cycle.
- Writes produce no rvalid. A read granted the cycle after a write to the same address returns the new data (RAM order preserved).
- Reset mid-operation: in-flight tags are discarded; no rvalid follows for reads granted before reset.
- Idle requesters: no effect on the pointer.

Decomposition:
- Package ram_arb_pkg holds:
  - DW, AW, RD_LAT defaults
  - typedef ram_req_t {wr, addr, wdata}
  - typedef rd_tag_t {vld, id}
- One sub-module: rd_tag_pipe. It is a parameterised shift register of rd_tag_t, depth 1+RD_LAT, cleared by rst.
- The top level holds the arbiter, pointer and RAM-port registers.

Test Plan:
- Reset: hold rst=0 with req0=req1=1 -> gnt0=gnt1=0 is not required, but ram_wr=0, ram_addr=0, rvalid0=rvalid1=0 throughout; after release the first grant goes to requester 0.
- Single write then read: req0 writes addr=4'h3 wdata=8'hA5; next cycle req0 reads addr=4'h3 -> ram_wr=1 one cycle after the write grant; rvalid0=1 with rdata=8'hA5 exactly 3 cycles after the read grant; rvalid1 stays 0.
- Contention with RR_EN=1: req0 and req1 both held high for 4 reads (addr0=1, addr1=2) -> grant order 0,1,0,1; rvalid alternates 0,1,0,1 with the correct data per address.
- Fixed priority with RR_EN=0: both requesters request continuously -> gnt1 never asserts while req0=1; gnt1 asserts the first cycle req0 drops.
- Back-to-back reads from requester 1 to addr 0..15 after preloading data=addr*3 -> 16 consecutive rvalid1 pulses in order, rdata = 8'h00, 8'h03, ... 8'h2D, with no bubbles.
- Reset mid-read: grant a read on requester 0, assert rst=0 the next cycle -> no rvalid0 ever appears for that read; the pointer returns to 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared defaults and types for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_DW     = 8;
  localparam int unsigned DEF_AW     = 4;
  localparam int unsigned DEF_RD_LAT = 1;

  // One RAM access as presented on the RAM port
  typedef struct packed {
    logic              wr;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } ram_req_t;

  // Read-return tag: which requester a pending read belongs to
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles both requester ports, the read-return bus and the RAM port.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) ();

  logic          req0;
  logic          wr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic          wr1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;

  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, ram_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, ram_wr, ram_addr, ram_wdata
  );

  // Requester / RAM side
  modport master (
    output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, ram_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, ram_wr, ram_addr, ram_wdata
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register carrying read tags alongside the RAM read latency.
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1 + DEF_RD_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];

  // Advance one stage per cycle; reset discards every in-flight tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin / fixed-priority arbiter in front of a single-port SRAM.
// DW/AW must match the package defaults, since ram_req_t is sized by them.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  logic     ptr_q, ptr_d;  // 0 favours requester 0 when both request
  logic     gnt0, gnt1;
  ram_req_t sel_req;
  ram_req_t ram_q;
  rd_tag_t  tag_in, tag_out;
  logic     rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata_q;

  // Grant selection, next pointer and the request to be issued
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    ptr_d   = ptr_q;
    sel_req = '{wr: bus.wr0, addr: bus.addr0, wdata: bus.wdata0};
    if (bus.req0 && (!bus.req1 || !RR_EN || !ptr_q)) begin
      gnt0 = 1'b1;
    end else if (bus.req1) begin
      gnt1 = 1'b1;
    end
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d   = 1'b0;
      sel_req = '{wr: bus.wr1, addr: bus.addr1, wdata: bus.wdata1};
    end
    tag_in = '{vld: (gnt0 | gnt1) & ~sel_req.wr, id: gnt1};
  end

  // Pointer and RAM-port registers; addr/wdata hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
      ram_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      ram_q.wr <= (gnt0 | gnt1) & sel_req.wr;
      if (gnt0 || gnt1) begin
        ram_q.addr  <= sel_req.addr;
        ram_q.wdata <= sel_req.wdata;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Capture RAM read data when its tag emerges and flag the owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid0_q <= tag_out.vld & ~tag_out.id;
      rvalid1_q <= tag_out.vld & tag_out.id;
      if (tag_out.vld) rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_wr    = ram_q.wr;
  assign bus.ram_addr  = ram_q.addr;
  assign bus.ram_wdata = ram_q.wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench: round-robin arbiter against a transaction-level reference model,
// plus a fixed-priority instance sharing the same request stimulus.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DW(8), .AW(4)) bus_a ();
  ram_arbiter_if #(.DW(8), .AW(4)) bus_b ();

  ram_arbiter #(.DW(8), .AW(4), .RD_LAT(1), .RR_EN(1'b1)) u_dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ram_arbiter #(.DW(8), .AW(4), .RD_LAT(1), .RR_EN(1'b0)) u_dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Fixed-priority instance sees the same requests
  assign bus_b.req0      = bus_a.req0;
  assign bus_b.wr0       = bus_a.wr0;
  assign bus_b.addr0     = bus_a.addr0;
  assign bus_b.wdata0    = bus_a.wdata0;
  assign bus_b.req1      = bus_a.req1;
  assign bus_b.wr1       = bus_a.wr1;
  assign bus_b.addr1     = bus_a.addr1;
  assign bus_b.wdata1    = bus_a.wdata1;
  assign bus_b.ram_rdata = 8'h00;

  // 16x8 SRAM with one cycle of read latency
  logic [7:0] mem_a [16];
  always @(posedge clk) begin
    if (bus_a.ram_wr) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
    bus_a.ram_rdata <= mem_a[bus_a.ram_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t    rq[$];
  logic [7:0] ref_mem [16];
  int         fav = 0;
  bit         in_rst = 1'b1;
  bit         exp_wr = 1'b0;
  logic [3:0] exp_addr = '0;
  logic [7:0] exp_wdata = '0;
  int         cyc = 0;
  bit         eg0, eg1;
  int         last_gnt = -1;
  int         rv1_seen = 0;
  int         pre_rst_reads = 0;

  task automatic drive(input int n, input logic r, input logic w, input logic [3:0] a,
                       input logic [7:0] d);
    if (n == 0) begin
      bus_a.req0 = r; bus_a.wr0 = w; bus_a.addr0 = a; bus_a.wdata0 = d;
    end else begin
      bus_a.req1 = r; bus_a.wr1 = w; bus_a.addr1 = a; bus_a.wdata1 = d;
    end
  endtask

  task automatic model_reset();
    fav = 0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    rq.delete();
  endtask

  // One clock cycle: compare at negedge, advance model, return at posedge+1
  task automatic tick();
    logic r0, r1;
    @(negedge clk);
    r0 = bus_a.req0;
    r1 = bus_a.req1;
    last_gnt = bus_a.gnt1 ? 1 : (bus_a.gnt0 ? 0 : -1);
    if (in_rst) begin
      eg0 = 1'b0; eg1 = 1'b0;
      check_eq("rst_ram_wr",   32'(bus_a.ram_wr),   32'(0));
      check_eq("rst_ram_addr", 32'(bus_a.ram_addr), 32'(0));
      check_eq("rst_rvalid0",  32'(bus_a.rvalid0),  32'(0));
      check_eq("rst_rvalid1",  32'(bus_a.rvalid1),  32'(0));
      check_eq("rst_rdata",    32'(bus_a.rdata),    32'(0));
    end else begin
      if (r0 && r1) begin
        eg0 = (fav == 0); eg1 = !eg0;
      end else begin
        eg0 = r0; eg1 = r1;
      end
      check_eq("gnt0", 32'(bus_a.gnt0), 32'(eg0));
      check_eq("gnt1", 32'(bus_a.gnt1), 32'(eg1));
      check_eq("ram_wr", 32'(bus_a.ram_wr), 32'(exp_wr));
      check_eq("ram_addr", 32'(bus_a.ram_addr), 32'(exp_addr));
      check_eq("ram_wdata", 32'(bus_a.ram_wdata), 32'(exp_wdata));
      if (rq.size() > 0 && rq[0].due == cyc) begin
        check_eq("rvalid0", 32'(bus_a.rvalid0), 32'(rq[0].id == 0));
        check_eq("rvalid1", 32'(bus_a.rvalid1), 32'(rq[0].id == 1));
        check_eq("rdata", 32'(bus_a.rdata), 32'(rq[0].data));
        void'(rq.pop_front());
      end else begin
        check_eq("rvalid0_idle", 32'(bus_a.rvalid0), 32'(0));
        check_eq("rvalid1_idle", 32'(bus_a.rvalid1), 32'(0));
      end
      check_eq("fp_gnt0", 32'(bus_b.gnt0), 32'(r0));
      check_eq("fp_gnt1", 32'(bus_b.gnt1), 32'(r1 && !r0));
      if (bus_a.rvalid1) rv1_seen++;
      if (eg0 || eg1) begin
        exp_wr    = eg1 ? bus_a.wr1    : bus_a.wr0;
        exp_addr  = eg1 ? bus_a.addr1  : bus_a.addr0;
        exp_wdata = eg1 ? bus_a.wdata1 : bus_a.wdata0;
        if (exp_wr) ref_mem[exp_addr] = exp_wdata;
        else rq.push_back('{due: cyc + 3, id: (eg1 ? 1 : 0), data: ref_mem[exp_addr]});
        fav = eg0 ? 1 : 0;
      end else begin
        exp_wr = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, k, guard;
    int exp_order [4] = '{0, 1, 0, 1};

    // Reset held with both requesting writes
    drive(0, 1'b1, 1'b1, 4'h0, 8'h00);
    drive(1, 1'b1, 1'b1, 4'h1, 8'h03);
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    in_rst = 1'b0;
    tick();
    check_eq("first_gnt", 32'(last_gnt), 32'(0));
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    tick();
    idle(1);

    // Preload data = addr*3 from requester 1
    for (int i = 0; i < 16; i++) begin
      drive(1, 1'b1, 1'b1, 4'(i), 8'(i * 3));
      tick();
    end

    // Back-to-back reads from requester 1
    rv1_seen = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1'b1, 1'b0, 4'(i), 8'h00);
      tick();
    end
    idle(4);
    check_eq("b2b_rvalid1_count", 32'(rv1_seen), 32'(16));

    // Contention: two reads each, addr0=1 addr1=2
    n0 = 2; n1 = 2; k = 0; guard = 0;
    while ((n0 > 0 || n1 > 0) && guard < 20) begin
      drive(0, n0 > 0, 1'b0, 4'h1, 8'h00);
      drive(1, n1 > 0, 1'b0, 4'h2, 8'h00);
      tick();
      if (k < 4) check_eq("cont_order", 32'(last_gnt), 32'(exp_order[k]));
      k++;
      if (eg0) n0--;
      if (eg1) n1--;
      guard++;
    end
    check_eq("cont_done", 32'(guard), 32'(4));
    idle(4);

    // Single write then read on requester 0
    drive(0, 1'b1, 1'b1, 4'h3, 8'hA5);
    tick();
    drive(0, 1'b1, 1'b0, 4'h3, 8'h00);
    tick();
    idle(5);

    // Randomised traffic, requesters hold until granted
    for (int n = 0; n < 300; n++) begin
      if (!bus_a.req0 || eg0)
        drive(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if (!bus_a.req1 || eg1)
        drive(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      tick();
    end
    idle(6);

    // Reset right after a read grant discards it
    drive(0, 1'b1, 1'b0, 4'h5, 8'h00);
    tick();
    pre_rst_reads = rq.size();
    check_eq("mid_rst_read_queued", 32'(pre_rst_reads), 32'(1));
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    rst = 1'b0;
    in_rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    in_rst = 1'b0;
    idle(5);
    drive(0, 1'b1, 1'b0, 4'h6, 8'h00);
    drive(1, 1'b1, 1'b0, 4'h7, 8'h00);
    tick();
    check_eq("ptr_after_rst", 32'(last_gnt), 32'(0));
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    tick();
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
